// File: rtl/isr_ctrl.sv
// rtl/isr_ctrl.sv - interrupt cause capture, jisr strobe, boot interrupt and flush sequencing
// Optional macro EXT_IRQ_EDGE_EN: sticky edge-detected external requests with software clear.
module isr_ctrl #(
  parameter int NCAUSE       = 23,
  parameter int NEXT         = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              commit_en,
  input  logic [6:0]        int_cause,
  input  logic [NEXT-1:0]   ext_irq,
  input  logic              irq_clr_we,
  input  logic [NEXT-1:0]   irq_clr,
  input  logic [31:0]       sr,
  output logic              jisr,
  output logic [NCAUSE-1:0] mca,
  output logic              rpt,
  output logic [4:0]        il,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_IDLE,
    ST_DRAIN
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_next;
  logic [NEXT-1:0]   w_req;
  logic [NCAUSE-1:0] w_idle_mca;
  logic [NCAUSE-1:0] w_mca;
  logic              w_jisr;
  logic              w_busy;
  logic [4:0]        w_il;
  logic              w_unused;

`ifdef EXT_IRQ_EDGE_EN
  logic [NEXT-1:0] r_ext_q;
  logic [NEXT-1:0] r_pend;

  // A new rising edge wins over a same-cycle software clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ext_q <= '0;
      r_pend  <= '0;
    end else begin
      r_ext_q <= ext_irq;
      r_pend  <= (r_pend & ~({NEXT{irq_clr_we}} & irq_clr)) | (ext_irq & ~r_ext_q);
    end
  end

  assign w_req    = r_pend;
  assign w_unused = ^{int_cause[0], sr[5:0], sr[31:NCAUSE]};
`else
  assign w_req    = ext_irq;
  assign w_unused = ^{int_cause[0], sr[5:0], sr[31:NCAUSE], irq_clr_we, irq_clr};
`endif

  always_comb begin
    w_idle_mca = '0;
    for (int i = 1; i <= 6; i++) begin
      w_idle_mca[i] = commit_en & int_cause[i];
    end
    w_idle_mca[6] = w_idle_mca[6] & sr[6];
    for (int k = 0; k < NEXT; k++) begin
      w_idle_mca[7+k] = w_req[k] & sr[7+k];
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_jisr     = 1'b0;
    w_mca      = '0;
    w_busy     = 1'b1;
    if (!reset) begin
      case (r_state)
        ST_BOOT: begin
          w_jisr     = 1'b1;
          w_mca      = NCAUSE'(1);
          w_next     = ST_DRAIN;
          w_cnt_next = CNT_LOAD;
        end
        ST_IDLE: begin
          w_busy = 1'b0;
          w_mca  = w_idle_mca;
          w_jisr = commit_en & (|w_idle_mca);
          if (w_jisr) begin
            w_next     = ST_DRAIN;
            w_cnt_next = CNT_LOAD;
          end
        end
        ST_DRAIN: begin
          if (r_cnt == 4'd0) begin
            w_next = ST_IDLE;
          end else begin
            w_cnt_next = r_cnt - 4'd1;
          end
        end
        default: begin
          w_next = ST_BOOT;
        end
      endcase
    end
  end

  // Lowest set index has highest priority.
  always_comb begin
    w_il = 5'd0;
    for (int i = NCAUSE - 1; i >= 0; i--) begin
      if (w_mca[i]) begin
        w_il = 5'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BOOT;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign jisr = w_jisr;
  assign mca  = w_mca;
  assign il   = w_il;
  assign rpt  = (|w_mca) && (w_il >= 5'd1) && (w_il <= 5'd4);
  assign busy = w_busy;

endmodule

// File: tb/tb_isr_ctrl.sv
// tb/tb_isr_ctrl.sv - self-checking bench for isr_ctrl against a cycle-level behavioural model
module tb_isr_ctrl;

  localparam int FLUSH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        commit_en;
  logic [6:0]  int_cause;
  logic [15:0] ext_irq;
  logic        irq_clr_we;
  logic [15:0] irq_clr;
  logic [31:0] sr;
  logic        jisr;
  logic [22:0] mca;
  logic        rpt;
  logic [4:0]  il;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // model: 0 = boot, 1 = idle, 2 = drain
  int          m_st = 0;
  int          m_cnt = 0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_extq = '0;
  logic        e_jisr, e_rpt, e_busy;
  logic [22:0] e_mca;
  logic [4:0]  e_il;

  isr_ctrl dut (
    .clk(clk), .reset(reset), .commit_en(commit_en), .int_cause(int_cause),
    .ext_irq(ext_irq), .irq_clr_we(irq_clr_we), .irq_clr(irq_clr), .sr(sr),
    .jisr(jisr), .mca(mca), .rpt(rpt), .il(il), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ce, input logic [6:0] ic, input logic [15:0] ex,
                       input logic cwe, input logic [15:0] cl, input logic [31:0] s);
    reset = rst; commit_en = ce; int_cause = ic; ext_irq = ex;
    irq_clr_we = cwe; irq_clr = cl; sr = s;
  endtask

  task automatic model_eval();
    logic req;
    bit   found;
    e_jisr = 1'b0; e_mca = '0; e_rpt = 1'b0; e_il = '0; e_busy = 1'b1;
    if (!reset) begin
      if (m_st == 0) begin
        e_jisr = 1'b1;
        e_mca  = 23'h1;
      end else if (m_st == 1) begin
        e_busy = 1'b0;
        for (int i = 1; i <= 6; i++)
          if (commit_en && int_cause[i] && (i < 6 || sr[i])) e_mca[i] = 1'b1;
        for (int k = 0; k < 16; k++) begin
`ifdef EXT_IRQ_EDGE_EN
          req = m_pend[k];
`else
          req = ext_irq[k];
`endif
          if (req && sr[7+k]) e_mca[7+k] = 1'b1;
        end
        e_jisr = commit_en && (e_mca != 0);
      end
    end
    found = 0;
    for (int i = 0; i < 23; i++)
      if (!found && e_mca[i]) begin
        e_il = 5'(i);
        found = 1;
      end
    e_rpt = found && (e_il >= 1) && (e_il <= 4);
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    chk("jisr", 32'(jisr), 32'(e_jisr));
    chk("mca",  32'(mca),  32'(e_mca));
    chk("il",   32'(il),   32'(e_il));
    chk("rpt",  32'(rpt),  32'(e_rpt));
    chk("busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic advance();
    if (reset) begin
      m_st = 0; m_cnt = 0; m_pend = '0; m_extq = '0;
    end else begin
      m_pend = (m_pend & ~(irq_clr_we ? irq_clr : 16'h0)) | (ext_irq & ~m_extq);
      m_extq = ext_irq;
      if (m_st == 0) begin
        m_st = 2; m_cnt = FLUSH - 1;
      end else if (m_st == 1) begin
        if (e_jisr) begin
          m_st = 2; m_cnt = FLUSH - 1;
        end
      end else if (m_cnt == 0) begin
        m_st = 1;
      end else begin
        m_cnt--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    logic [6:0]  ic;
    logic [15:0] ex;

    // reset held 3 cycles
    drive(1, 1, 7'h08, 16'hFFFF, 0, 0, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("rst_busy", 32'(busy), 1);
      chk("rst_jisr", 32'(jisr), 0);
      advance();
    end

    // boot interrupt then two flush cycles
    drive(0, 1, 7'h08, 16'h0000, 0, 0, 32'h0);
    sample();
    chk("boot_jisr", 32'(jisr), 1);
    chk("boot_mca", 32'(mca), 32'h1);
    chk("boot_rpt", 32'(rpt), 0);
    advance();
    drive(0, 0, 7'h00, 16'h0000, 0, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("boot_drain_busy", 32'(busy), 1);
      advance();
    end
    sample();
    chk("idle_busy", 32'(busy), 0);
    advance();

    // page fault on fetch
    drive(0, 1, 7'b0001000, 16'h0000, 0, 0, 32'h0);
    sample();
    chk("pf_jisr", 32'(jisr), 1);
    chk("pf_mca", 32'(mca), 32'h8);
    chk("pf_il", 32'(il), 3);
    chk("pf_rpt", 32'(rpt), 1);
    advance();
    drive(0, 0, 7'h00, 16'h0000, 0, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("pf_drain_jisr", 32'(jisr), 0);
      advance();
    end

    // overflow masked, then enabled
    drive(0, 1, 7'b1000000, 16'h0000, 0, 0, 32'h0);
    sample();
    chk("ovf_masked_jisr", 32'(jisr), 0);
    advance();
    drive(0, 1, 7'b1000000, 16'h0000, 0, 0, 32'hFFFFFFFF);
    sample();
    chk("ovf_jisr", 32'(jisr), 1);
    chk("ovf_il", 32'(il), 6);
    chk("ovf_rpt", 32'(rpt), 0);
    advance();
    drive(0, 0, 7'h00, 16'h0000, 0, 0, 32'hFFFFFFFF);
    for (int i = 0; i < 2; i++) begin
      sample();
      advance();
    end

    // simultaneous misaligned + trap + external 0
    drive(0, 1, 7'b0100100, 16'h0001, 0, 0, 32'hFFFFFFFF);
    sample();
`ifndef EXT_IRQ_EDGE_EN
    chk("multi_mca", 32'(mca), 32'hA4);
`endif
    chk("multi_il", 32'(il), 2);
    chk("multi_rpt", 32'(rpt), 1);
    advance();

    // external 3 raised during drain is deferred
    drive(0, 1, 7'h00, 16'h0008, 0, 0, 32'hFFFFFFFF);
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("drain_no_jisr", 32'(jisr), 0);
      advance();
    end
    sample();
    chk("defer_jisr", 32'(jisr), 1);
`ifndef EXT_IRQ_EDGE_EN
    chk("defer_mca", 32'(mca), 32'h400);
    chk("defer_il", 32'(il), 10);
`endif
    chk("defer_rpt", 32'(rpt), 0);
    advance();
    drive(0, 0, 7'h00, 16'h0000, 0, 0, 32'hFFFFFFFF);
    for (int i = 0; i < 2; i++) begin
      sample();
      advance();
    end

`ifdef EXT_IRQ_EDGE_EN
    drive(0, 0, 7'h00, 16'h0000, 1, 16'hFFFF, 32'hFFFFFFFF);
    sample();
    advance();
    drive(0, 0, 7'h00, 16'h0002, 0, 0, 32'hFFFFFFFF);
    sample();
    advance();
    drive(0, 0, 7'h00, 16'h0000, 0, 0, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("edge_pend_held", 32'(mca), 32'h100);
      chk("edge_no_jisr", 32'(jisr), 0);
      advance();
    end
    drive(0, 1, 7'h00, 16'h0000, 0, 0, 32'hFFFFFFFF);
    sample();
    chk("edge_jisr", 32'(jisr), 1);
    chk("edge_il", 32'(il), 8);
    advance();
    drive(0, 0, 7'h00, 16'h0000, 1, 16'h0002, 32'hFFFFFFFF);
    sample();
    advance();
    drive(0, 0, 7'h00, 16'h0000, 0, 0, 32'hFFFFFFFF);
    sample();
    advance();
    sample();
    chk("edge_cleared", 32'(mca), 0);
    advance();
    drive(0, 0, 7'h00, 16'h0004, 1, 16'h0004, 32'hFFFFFFFF);
    sample();
    advance();
    drive(0, 0, 7'h00, 16'h0000, 0, 0, 32'hFFFFFFFF);
    sample();
    chk("edge_set_beats_clr", 32'(mca), 32'h200);
    advance();
`endif

    // randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      r  = $urandom;
      ic = (r[1:0] == 2'b00) ? {r[7:2], 1'b0} : 7'h00;
      r  = $urandom;
      ex = r[15:0] & r[31:16];
      r  = $urandom;
      ex = ex & r[15:0];
      drive(($urandom_range(0, 59) == 0), r[16], ic, ex, r[17],
            16'($urandom), (r[18] ? 32'hFFFFFFFF : $urandom));
      sample();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
